ram_dp_clr: RTL and testbench

Parametrised single-clock true dual-port RAM with per-lane byte enables, gated registered read data, same-address collision forwarding, and a hardware clear sequencer. It zeroes the whole array after reset or on request. It replaces the fixed-geometry single-port and vendor dual-port RAM wrappers in the memory subsystem. The array is inferred behaviourally, with no vendor primitive, so the same RTL targets any FPGA family.

---
 rtl/ram_dp_clr.sv | 117 +++++++++++
 tb/tb_ram_dp_clr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// Single-clock true dual-port RAM with per-lane write enables, gated registered read data,
// same-address write forwarding and a sequencer that zeroes the whole array.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | normal two-port operation
//   CLR   | one zero-word per enabled edge at clr_cnt_q; port accesses dropped
module ram_dp_clr #(
  parameter int CAddrLen    = 8,
  parameter int CDataLen    = 16,
  parameter int CByteLen    = 8,
  parameter bit CClrOnReset = 1'b1
) (
  input  logic                             AClkH,
  input  logic                             AResetH,
  input  logic                             AClkHEn,
  input  logic [CAddrLen-1:0]              AAddrA,
  input  logic [CDataLen-1:0]              AMosiA,
  input  logic [CDataLen/CByteLen-1:0]     AWrEnA,
  input  logic                             ARdEnA,
  output logic [CDataLen-1:0]              AMisoA,
  input  logic [CAddrLen-1:0]              AAddrB,
  input  logic [CDataLen-1:0]              AMosiB,
  input  logic [CDataLen/CByteLen-1:0]     AWrEnB,
  input  logic                             ARdEnB,
  output logic [CDataLen-1:0]              AMisoB,
  input  logic                             AClrReq,
  output logic                             ABusy
);

  localparam int CLanes = CDataLen / CByteLen;
  localparam int CDepth = 2 ** CAddrLen;
  localparam logic [CAddrLen-1:0] CCntOne = CAddrLen'(1);

  typedef enum logic {IDLE = 1'b0, CLR = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CAddrLen-1:0] clr_cnt_q, clr_cnt_d;
  logic [CDataLen-1:0] mem_q [CDepth];
  logic [CDataLen-1:0] rdata_a_q, rdata_b_q;
  logic                rd_en_a_q, rd_en_b_q;
  logic [CDataLen-1:0] fwd_a, fwd_b;
  logic [CLanes-1:0]   we_a, we_b;
  logic                busy;

  assign busy = (state_q == CLR);
  assign ABusy = busy;
  assign we_a = busy ? '0 : AWrEnA;
  assign we_b = busy ? '0 : AWrEnB;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: if (AClrReq) state_d = CLR;
      CLR: begin
        clr_cnt_d = clr_cnt_q + CCntOne;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state_q   <= CClrOnReset ? CLR : IDLE;
      clr_cnt_q <= '0;
    end else if (AClkHEn) begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Port B is applied first so that port A wins lanes written by both ports.
  always_ff @(posedge AClkH) begin
    if (!AResetH && AClkHEn) begin
      if (busy) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        for (int i = 0; i < CLanes; i++) begin
          if (we_b[i]) mem_q[AAddrB][i*CByteLen +: CByteLen] <= AMosiB[i*CByteLen +: CByteLen];
          if (we_a[i]) mem_q[AAddrA][i*CByteLen +: CByteLen] <= AMosiA[i*CByteLen +: CByteLen];
        end
      end
    end
  end

  // Read words as they will be after this edge's writes, with the same A-over-B lane priority.
  always_comb begin
    fwd_a = mem_q[AAddrA];
    fwd_b = mem_q[AAddrB];
    for (int i = 0; i < CLanes; i++) begin
      if (we_b[i] && (AAddrB == AAddrA)) fwd_a[i*CByteLen +: CByteLen] = AMosiB[i*CByteLen +: CByteLen];
      if (we_a[i])                       fwd_a[i*CByteLen +: CByteLen] = AMosiA[i*CByteLen +: CByteLen];
      if (we_b[i])                       fwd_b[i*CByteLen +: CByteLen] = AMosiB[i*CByteLen +: CByteLen];
      if (we_a[i] && (AAddrA == AAddrB)) fwd_b[i*CByteLen +: CByteLen] = AMosiA[i*CByteLen +: CByteLen];
    end
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      rd_en_a_q <= 1'b0;
      rd_en_b_q <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else if (AClkHEn) begin
      rd_en_a_q <= ARdEnA & ~busy;
      rd_en_b_q <= ARdEnB & ~busy;
      rdata_a_q <= fwd_a;
      rdata_b_q <= fwd_b;
    end
  end

  assign AMisoA = rd_en_a_q ? rdata_a_q : '0;
  assign AMisoB = rd_en_b_q ? rdata_b_q : '0;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr at 16 x 16-bit: expected read words are queued when the
// request is driven and compared one edge later; busy timing is checked against fixed counts.
module tb_ram_dp_clr;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] mosi_a, mosi_b, miso_a, miso_b;
  logic [1:0]  wr_a, wr_b;
  logic        rd_a, rd_b, clr_req, busy;

  typedef struct {
    string       tag;
    bit          port;
    logic [15:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] mdl [16];
  int          n_cmp = 0;
  int          n_err = 0;

  ram_dp_clr #(.CAddrLen(4), .CDataLen(16), .CByteLen(8), .CClrOnReset(1'b1)) dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .AAddrA(addr_a), .AMosiA(mosi_a), .AWrEnA(wr_a), .ARdEnA(rd_a), .AMisoA(miso_a),
    .AAddrB(addr_b), .AMosiB(mosi_b), .AWrEnB(wr_b), .ARdEnB(rd_b), .AMisoB(miso_b),
    .AClrReq(clr_req), .ABusy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, e.port ? miso_b : miso_a, e.exp);
    end
  endtask

  task automatic idle_inputs();
    wr_a = '0; wr_b = '0; rd_a = 1'b0; rd_b = 1'b0; clr_req = 1'b0;
  endtask

  // One idle-state access on both ports; the model takes the writes (B then A) before
  // the reads are predicted, which is exactly what forwarding should return.
  task automatic acc(input logic [3:0] aa, input logic [15:0] da, input logic [1:0] wa, input logic ra,
                     input logic [3:0] ab, input logic [15:0] db, input logic [1:0] wb, input logic rb,
                     input string tag);
    addr_a = aa; mosi_a = da; wr_a = wa; rd_a = ra;
    addr_b = ab; mosi_b = db; wr_b = wb; rd_b = rb;
    for (int i = 0; i < 2; i++) if (wb[i]) mdl[ab][i*8 +: 8] = db[i*8 +: 8];
    for (int i = 0; i < 2; i++) if (wa[i]) mdl[aa][i*8 +: 8] = da[i*8 +: 8];
    sb_q.push_back('{tag: {tag, "_a"}, port: 1'b0, exp: ra ? mdl[aa] : 16'h0000});
    sb_q.push_back('{tag: {tag, "_b"}, port: 1'b1, exp: rb ? mdl[ab] : 16'h0000});
    step();
  endtask

  // Busy phase: writes on A are offered and must be dropped, reads on B must return zero.
  task automatic busy_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, busy, 1'b1);
      addr_a = 4'd2; mosi_a = 16'hFFFF; wr_a = 2'b11; rd_a = 1'b0;
      addr_b = 4'(i); rd_b = 1'b1; wr_b = '0;
      sb_q.push_back('{tag: {tag, "_rd"}, port: 1'b1, exp: 16'h0000});
      step();
    end
    idle_inputs();
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
  endtask

  initial begin
    addr_a = '0; addr_b = '0; mosi_a = '0; mosi_b = '0;
    idle_inputs();
    en  = 1'b1;
    rst = 1'b1;
    step();
    check("rst_busy", busy, 1'b1);
    check("rst_miso_a", miso_a, 16'h0000);
    check("rst_miso_b", miso_b, 16'h0000);
    rst = 1'b0;

    busy_cycles(16, "por_clr");
    check("por_clr_done", busy, 1'b0);
    zero_model();
    for (int i = 0; i < 16; i++) acc(4'(i), 16'h0, 2'b00, 1'b1, 4'(15 - i), 16'h0, 2'b00, 1'b1, "por_zero");

    acc(4'd3, 16'hA55A, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "wr3_full");
    acc(4'd3, 16'h12FF, 2'b10, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "wr3_hi");
    acc(4'd0, 16'h0, 2'b00, 1'b0, 4'd3, 16'h0, 2'b00, 1'b1, "rd3");
    check("rd3_const", miso_b, 16'h125A);
    acc(4'd0, 16'h0, 2'b00, 1'b0, 4'd3, 16'h0, 2'b00, 1'b0, "rd3_noen");

    acc(4'd5, 16'h1111, 2'b11, 1'b0, 4'd5, 16'h2222, 2'b01, 1'b0, "ww5_a11");
    acc(4'd5, 16'h0, 2'b00, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, "rd5_1");
    check("rd5_1_const", miso_a, 16'h1111);
    acc(4'd5, 16'h1111, 2'b10, 1'b1, 4'd5, 16'h2222, 2'b01, 1'b1, "ww5_a10_fwd");
    check("ww5_fwd_const", miso_b, 16'h1122);

    acc(4'd7, 16'hBEEF, 2'b11, 1'b0, 4'd7, 16'h0, 2'b00, 1'b1, "xfwd7");
    check("xfwd7_const", miso_b, 16'hBEEF);

    for (int k = 0; k < 40; k++)
      acc(4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom), 1'($urandom),
          4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom), 1'($urandom), "rand");

    clr_req = 1'b1;
    acc(4'd2, 16'h00FF, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "clr_wr2");
    clr_req = 1'b0;
    check("clr_req_busy", busy, 1'b1);
    busy_cycles(5, "req_clr_a");
    clr_req = 1'b1;
    busy_cycles(1, "req_clr_ign");
    busy_cycles(10, "req_clr_b");
    check("req_clr_done", busy, 1'b0);
    zero_model();
    acc(4'd2, 16'h0, 2'b00, 1'b1, 4'd7, 16'h0, 2'b00, 1'b1, "after_clr");

    acc(4'd9, 16'h5A5A, 2'b11, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "wr9");
    acc(4'd9, 16'h0, 2'b00, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, "rd9");
    en = 1'b0;
    addr_a = 4'd9; mosi_a = 16'hFFFF; wr_a = 2'b11; rd_a = 1'b0; clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en0_hold_miso", miso_a, 16'h5A5A);
      check("en0_no_clr", busy, 1'b0);
    end
    idle_inputs();
    en = 1'b1;
    acc(4'd9, 16'h0, 2'b00, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, "en0_no_wr");

    clr_req = 1'b1;
    acc(4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "frz_start");
    clr_req = 1'b0;
    busy_cycles(5, "frz_pre");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_busy", busy, 1'b1);
    end
    en = 1'b1;
    busy_cycles(11, "frz_post");
    check("frz_done", busy, 1'b0);

    clr_req = 1'b1;
    acc(4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 2'b00, 1'b0, "mid_rst_start");
    clr_req = 1'b0;
    busy_cycles(5, "mid_rst_pre");
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_cycles(16, "mid_rst_post");
    check("mid_rst_done", busy, 1'b0);
    zero_model();
    acc(4'd3, 16'h0, 2'b00, 1'b1, 4'd15, 16'h0, 2'b00, 1'b1, "final_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
